// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch sequencer: turns the memory's registered 3-word window into one
// variable-length instruction per handshake, and runs block copies between instructions.
module imem_fetch_ctrl #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int          LEN_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             redirect_valid,
  input  logic [15:0]      redirect_addr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_inst0,
  output logic [15:0]      out_inst1,
  output logic [15:0]      out_inst2,
  output logic [1:0]       out_len,
  output logic [15:0]      out_pc,
  output logic [15:0]      mem_addr,
  input  logic [15:0]      mem_inst0,
  input  logic [15:0]      mem_inst1,
  input  logic [15:0]      mem_inst2,
  output logic [15:0]      mem_wr_src,
  output logic [15:0]      mem_wr_dst,
  output logic             mem_wr_en,
  input  logic             copy_req,
  input  logic [15:0]      copy_src,
  input  logic [15:0]      copy_dst,
  input  logic [LEN_W-1:0] copy_len,
  output logic             copy_busy,
  output logic             copy_done
);

  localparam logic [1:0]  S_ISSUE    = 2'd0;
  localparam logic [1:0]  S_WAIT     = 2'd1;
  localparam logic [1:0]  S_HOLD     = 2'd2;
  localparam logic [1:0]  S_COPY     = 2'd3;
  localparam logic [14:0] RESET_WORD = 15'(RESET_PC >> 1);

  logic [1:0]       r_state;
  logic [14:0]      r_pc;
  logic             r_out_valid;
  logic [15:0]      r_inst0;
  logic [15:0]      r_inst1;
  logic [15:0]      r_inst2;
  logic [1:0]       r_len;
  logic [15:0]      r_out_pc;
  logic [15:0]      r_src;
  logic [15:0]      r_dst;
  logic [LEN_W-1:0] r_cnt;
  logic             r_wr_en;
  logic [15:0]      r_wr_src;
  logic [15:0]      r_wr_dst;
  logic             r_busy;
  logic             r_done;

  logic [1:0]       w_dec_len;
  logic [14:0]      w_redir_word;

  assign w_dec_len    = mem_inst0[15] ? (mem_inst0[14] ? 2'd3 : 2'd2) : 2'd1;
  assign w_redir_word = 15'(redirect_addr >> 1);

  // Copy outputs are issued one cycle ahead of the counter, so the first word
  // goes out on the cycle right after acceptance and the last one is followed
  // directly by the completion pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_ISSUE;
      r_pc        <= RESET_WORD;
      r_out_valid <= 1'b0;
      r_inst0     <= '0;
      r_inst1     <= '0;
      r_inst2     <= '0;
      r_len       <= '0;
      r_out_pc    <= {RESET_WORD, 1'b0};
      r_src       <= '0;
      r_dst       <= '0;
      r_cnt       <= '0;
      r_wr_en     <= 1'b0;
      r_wr_src    <= '0;
      r_wr_dst    <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_ISSUE: begin
          if (copy_req) begin
            r_state <= S_COPY;
            r_busy  <= 1'b1;
            if (copy_len != '0) begin
              r_wr_en  <= 1'b1;
              r_wr_src <= copy_src;
              r_wr_dst <= copy_dst;
              r_src    <= copy_src + 16'd1;
              r_dst    <= copy_dst + 16'd1;
              r_cnt    <= copy_len - LEN_W'(1);
            end else begin
              r_cnt  <= '0;
              r_done <= 1'b1;
            end
          end else if (run && !redirect_valid) begin
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (redirect_valid) begin
            r_state <= S_ISSUE;
          end else begin
            r_inst0     <= mem_inst0;
            r_inst1     <= (w_dec_len >= 2'd2) ? mem_inst1 : 16'h0000;
            r_inst2     <= (w_dec_len == 2'd3) ? mem_inst2 : 16'h0000;
            r_len       <= w_dec_len;
            r_out_pc    <= {r_pc, 1'b0};
            r_out_valid <= 1'b1;
            r_state     <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (redirect_valid) begin
            r_state <= S_ISSUE;
          end else if (out_ready) begin
            r_out_valid <= 1'b0;
            r_pc        <= r_pc + {13'd0, r_len};
            r_state     <= S_ISSUE;
          end
        end
        default: begin
          if (r_cnt != '0) begin
            r_wr_en  <= 1'b1;
            r_wr_src <= r_src;
            r_wr_dst <= r_dst;
            r_src    <= r_src + 16'd1;
            r_dst    <= r_dst + 16'd1;
            r_cnt    <= r_cnt - LEN_W'(1);
          end else begin
            // A zero-length copy already pulsed done at acceptance.
            r_wr_en <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= r_wr_en;
            r_state <= S_ISSUE;
          end
        end
      endcase
      if (redirect_valid) begin
        r_pc        <= w_redir_word;
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid  = r_out_valid;
  assign out_inst0  = r_inst0;
  assign out_inst1  = r_inst1;
  assign out_inst2  = r_inst2;
  assign out_len    = r_len;
  assign out_pc     = r_out_pc;
  assign mem_addr   = {r_pc, 1'b0};
  assign mem_wr_src = r_wr_src;
  assign mem_wr_dst = r_wr_dst;
  assign mem_wr_en  = r_wr_en;
  assign copy_busy  = r_busy;
  assign copy_done  = r_done;

endmodule
